// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: link > round-robin(A,B),
// one registered write per cycle, plus a pending-write scoreboard for decode stalls.
module rf_wb_arbiter #(
    parameter int LINK_REG = 31,
    parameter int NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    input  logic        link_valid,
    output logic        link_ready,
    input  logic [31:0] link_pc,
    input  logic        sb_set,
    input  logic [4:0]  sb_reg,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

    // ptr_q == 0: A wins the next A/B conflict; 1: B wins it
    logic             ptr_q, ptr_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic [NREGS-1:0] pending_q, pending_d;

    logic             grant;
    logic [4:0]       win_reg;
    logic [31:0]      win_data;

    always_comb begin
        link_ready = rst_n && link_valid;
        a_ready    = rst_n && a_valid && !link_valid && (!b_valid || !ptr_q);
        b_ready    = rst_n && b_valid && !link_valid && (!a_valid || ptr_q);
        grant      = link_ready || a_ready || b_ready;

        win_reg  = '0;
        win_data = '0;
        if (link_ready) begin
            win_reg  = LINK_ADDR;
            win_data = link_pc;
        end else if (a_ready) begin
            win_reg  = a_reg;
            win_data = a_data;
        end else if (b_ready) begin
            win_reg  = b_reg;
            win_data = b_data;
        end

        ptr_d = ptr_q;
        if (a_ready)
            ptr_d = 1'b1;
        else if (b_ready)
            ptr_d = 1'b0;

        // Writes to r0 complete the handshake but never reach the register file
        rf_we_d    = grant && (win_reg != 5'd0);
        rf_waddr_d = grant ? win_reg  : rf_waddr_q;
        rf_wdata_d = grant ? win_data : rf_wdata_q;

        // Set is applied after clear so a newer producer keeps the bit pending
        pending_d = pending_q;
        if (rf_we_d)
            pending_d[win_reg] = 1'b0;
        if (sb_set && (sb_reg != 5'd0))
            pending_d[sb_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rs_busy  = pending_q[rs] && (rs != 5'd0);
    assign rt_busy  = pending_q[rt] && (rt != 5'd0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized + directed bench for rf_wb_arbiter: a reference model predicts grants,
// busy bits and the write stream; a monitor checks register-file writes from a queue.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, link_valid;
    logic        a_ready, b_ready, link_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data, link_pc;
    logic        sb_set;
    logic [4:0]  sb_reg, rs, rt;
    logic        rs_busy, rt_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    rf_wb_arbiter #(.LINK_REG(31), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .link_valid(link_valid), .link_ready(link_ready), .link_pc(link_pc),
        .sb_set(sb_set), .sb_reg(sb_reg), .rs(rs), .rt(rt),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: outstanding writers per register, who last won A/B,
    // and the expected stream of register-file writes {addr, data}.
    bit          pend[32];
    int          last_ab;          // 0 = A last won, 1 = B last won
    logic [36:0] expq[$];
    bit          gA, gB, gL;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        last_ab = 1;
        expq.delete();
    endtask

    // One clock cycle: predict and check combinational outputs, advance the model.
    task automatic step();
        logic [4:0]  wreg;
        logic [31:0] wdata;
        @(negedge clk);
        gL = link_valid;
        gA = !gL && a_valid && (!b_valid || last_ab == 1);
        gB = !gL && b_valid && (!a_valid || last_ab == 0);
        check("ready{l,a,b}", {link_ready, a_ready, b_ready}, {gL, gA, gB});
        check("rs_busy", rs_busy, (rs != 0) && pend[rs]);
        check("rt_busy", rt_busy, (rt != 0) && pend[rt]);
        wreg = 0; wdata = 0;
        if (gL) begin wreg = 5'd31; wdata = link_pc; end
        else if (gA) begin wreg = a_reg; wdata = a_data; last_ab = 0; end
        else if (gB) begin wreg = b_reg; wdata = b_data; last_ab = 1; end
        if ((gL || gA || gB) && wreg != 0) begin
            expq.push_back({wreg, wdata});
            pend[wreg] = 1'b0;
        end
        if (sb_set && sb_reg != 0) pend[sb_reg] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write the DUT retires must be the next expected one.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rf_we) begin
                vectors++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write at %0t",
                             rf_waddr, rf_wdata, $time);
                end else begin
                    e = expq.pop_front();
                    if ({rf_waddr, rf_wdata} !== e) begin
                        errors++;
                        $display("FAIL write: got addr %0d data 0x%0h, required addr %0d data 0x%0h at %0t",
                                 rf_waddr, rf_wdata, e[36:32], e[31:0], $time);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; link_valid = 0; sb_set = 0;
        a_reg = 0; b_reg = 0; sb_reg = 0; a_data = 0; b_data = 0; link_pc = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rs = 0; rt = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rf_we", rf_we, 0);
        check("reset_rf_waddr", rf_waddr, 0);
        check("reset_rf_wdata", rf_wdata, 0);
        check("reset_ready", {link_ready, a_ready, b_ready}, 3'b000);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Idle: nothing busy for any queried register
        for (int i = 0; i < 4; i++) begin
            rs = 5'($urandom); rt = 5'($urandom);
            step();
        end

        // Single ALU write
        a_valid = 1; a_reg = 5; a_data = 32'hDEADBEEF;
        step();
        a_valid = 0;
        step(); step();

        // Three-way conflict: link, then A, then B
        link_valid = 1; link_pc = 32'h00400020;
        a_valid = 1; a_reg = 3; a_data = 32'h33333333;
        b_valid = 1; b_reg = 4; b_data = 32'h44444444;
        step();
        link_valid = 0;
        step();
        a_valid = 0;
        step();
        b_valid = 0;
        step(); step();

        // Round-robin fairness
        a_valid = 1; a_reg = 10; a_data = 32'hA0000000;
        b_valid = 1; b_reg = 11; b_data = 32'hB0000000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (gA) a_data = a_data + 1;
            if (gB) b_data = b_data + 1;
        end
        a_valid = 0; b_valid = 0;
        step();

        // Scoreboard set, clear by write, same-cycle set+clear
        rs = 7; rt = 8;
        sb_set = 1; sb_reg = 7;
        step();
        sb_set = 0;
        step();
        a_valid = 1; a_reg = 7; a_data = 32'h77777777;
        step();
        a_valid = 0;
        step();
        sb_set = 1; sb_reg = 7;
        step();
        a_valid = 1; a_data = 32'h77770001;
        step();
        a_valid = 0; sb_set = 0;
        step(); step();

        // Register 0: handshake only, no write, no scoreboard effect
        a_valid = 1; a_reg = 0; a_data = 32'h12345678;
        step();
        a_valid = 0;
        sb_set = 1; sb_reg = 0; rs = 0; rt = 0;
        step();
        sb_set = 0;
        step(); step();

        // Mid-operation reset while a write is on the port and r7 is pending
        rs = 7; rt = 9;
        sb_set = 1; sb_reg = 7;
        step();
        sb_set = 0;
        a_valid = 1; a_reg = 9; a_data = 32'h99999999;
        step();
        check("pre_reset_rf_we", rf_we, 1);
        rst_n = 0;
        #1;
        check("midreset_rf_we", rf_we, 0);
        check("midreset_rs_busy", rs_busy, 0);
        check("midreset_ready", {link_ready, a_ready, b_ready}, 3'b000);
        model_reset();
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Randomized traffic honouring the hold-until-granted rule
        gA = 1; gB = 1; gL = 1;
        for (int n = 0; n < 400; n++) begin
            if (!a_valid || gA) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_reg = 5'($urandom_range(0, 9)); a_data = $urandom;
            end
            if (!b_valid || gB) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_reg = 5'($urandom_range(0, 9)); b_data = $urandom;
            end
            if (!link_valid || gL) begin
                link_valid = ($urandom_range(0, 5) == 0);
                link_pc = $urandom;
            end
            sb_set = ($urandom_range(0, 2) == 0);
            sb_reg = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
            rs = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
            rt = 5'($urandom_range(0, 9));
            step();
        end

        idle_inputs();
        step(); step(); step();
        check("writes_drained", 64'(expq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between three writeback requesters:
  - ALU pipe (port A)
  - load/MEM pipe (port B)
  - link writes (jal/jalr return address to r31)
- Arbitrates one winner per cycle and registers the winning write into the register-file write port.
- Keeps a 32-entry pending-write scoreboard that the decode stage uses for stall decisions.
- Sits between the pipeline writeback stages and the register file.

Parameters:
- LINK_REG, 31, destination register index for link writes.
- NREGS, 32, scoreboard depth and register count; register index width is 5.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  ALU writeback request.
- a_ready  out  1  ALU request granted this cycle.
- a_reg  in  5  ALU destination register.
- a_data  in  32  ALU writeback data.
- b_valid  in  1  load writeback request.
- b_ready  out  1  load request granted this cycle.
- b_reg  in  5  load destination register.
- b_data  in  32  load writeback data.
- link_valid  in  1  link write request.
- link_ready  out  1  link request granted this cycle.
- link_pc  in  32  return address to write.
- sb_set  in  1  decode issued an instruction that will write sb_reg.
- sb_reg  in  5  destination register being marked pending.
- rs  in  5  decode source register 1 query.
- rt  in  5  decode source register 2 query.
- rs_busy  out  1  rs has an outstanding write.
- rt_busy  out  1  rt has an outstanding write.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Scoreboard all zeros.
  - Round-robin pointer points to A (A has priority on the first A/B conflict).
- Handshake:
  - A transfer occurs when x_valid && x_ready.
  - x_ready is combinational from the valid inputs and the pointer; at most one ready is high per cycle.
  - A requester not granted must hold valid, reg and data stable until granted.
- Arbitration order:
  - link first, always.
  - Then A vs B by round-robin.
  - The pointer toggles to the other A/B port only when A or B wins.
  - A link grant leaves the pointer unchanged.
- Write-port pipeline:
  - The winner's address and data are registered on the next rising edge.
  - rf_we=1 for exactly one cycle; latency is 1 cycle from grant to rf_we.
  - The register file has no backpressure, so one write retires per cycle.
  - No grant in a cycle → rf_we=0 next cycle; rf_waddr and rf_wdata hold their previous values.
- Register 0:
  - A granted write to reg 0 completes the handshake, but rf_we stays 0 for it.
  - A write to reg 0 never touches the scoreboard.
- Link writes:
  - Address is LINK_REG, data is link_pc.
  - The scoreboard bit for LINK_REG is cleared like any other write.
- Scoreboard update on each rising edge:
  - Clear bit rf_waddr_next when a granted write to a non-zero register is being registered.
  - Set bit sb_reg when sb_set && sb_reg != 0.
  - Set and clear of the same register in the same cycle: the set wins and the bit stays 1 (a newer producer is outstanding).
- Busy outputs:
  - rs_busy = pending[rs] && rs != 0; rt_busy likewise.
  - Both are combinational reads of the registered scoreboard, with no bypass of the same-cycle set/clear.
- Mid-operation reset:
  - All pending bits are dropped and any registered write is cancelled (rf_we=0 immediately).
  - Requesters see ready=0 while rst_n is low.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no valids → rf_we=0, rs_busy=rt_busy=0 for any rs/rt, all readies 0.
- Single ALU write: a_valid=1, a_reg=5, a_data=0xDEADBEEF → a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the following cycle rf_we=0.
- Three-way conflict held 3 cycles: link_valid, a_valid and b_valid all high, with a_reg=3, b_reg=4, link_pc=0x00400020 → grants in order link, A, B:
  - rf_waddr 31, 3, 4 on consecutive cycles.
  - rf_wdata for the link write is 0x00400020.
- Round-robin fairness: A and B both continuously valid for 6 cycles with no link → grants alternate A, B, A, B, A, B starting with A after reset.
- Scoreboard: sb_set with sb_reg=7 → rs=7 reads busy next cycle. Then A writes r7 → busy clears the cycle after the grant. Same-cycle sb_set r7 plus granted write to r7 → r7 stays busy.
- Reg 0 and mid-op reset:
  - a_reg=0 granted → a_ready=1, rf_we stays 0; sb_set with sb_reg=0 leaves rs=0 not busy.
  - Asserting rst_n low while rf_we=1 and pending=0x00000080 → rf_we=0 and rs=7 not busy immediately, without waiting for a clock edge.
